ctrl_pipe_stall: RTL
====================

Name: ctrl_pipe_stall

Overview:
- Parametrised successor to the D/E/M/W control pipeline of the pipelined ARM-subset core.
- Carries decoded control from Decode through Execute, Memory and Writeback.
- Owns the NZCV flag register and per-stage stall/flush.
- Carries a generic sideband bundle to Writeback.
- Adds what the earlier controller lacked: stall on E and M, flush on M, configurable ALU-control and sideband widths, and flag updates gated on instruction advance.

Parameters:
- ALU_W, 3, width of ALUControl field.
- SIDE_W, 8, width of sideband bundle carried D->W (e.g. destination tag); must be >=1.
- NV_NEVER, 1, 1: cond 4'b1111 never executes; 0: treated as AL.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- CondD  in  4  condition field of instruction in D.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD, IgRnD  in  1 each  decoded controls.
- ALUControlD  in  ALU_W  ALU operation.
- FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V.
- SideD  in  SIDE_W  sideband.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in E.
- StallE, StallM  in  1  hold E / M register.
- FlushE, FlushM  in  1  clear E / M register.
- ALUControlE  out  ALU_W
- ALUSrcE, MemtoRegE, IgRnE, PCSrcE  out  1
- CondExE  out  1  condition passes in E.
- BranchTakenE  out  1  BranchE & CondExE.
- Flags  out  4  architectural NZCV.
- PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1
- SideM  out  SIDE_W
- PCSrcW, RegWriteW, MemtoRegW  out  1
- SideW  out  SIDE_W

Behaviour:
- Reset (async): every pipeline register, Flags, and all outputs go to 0. A zeroed E entry has CondE=0 (EQ), but all enables are 0, so it has no effect.
- D->E register:
  - FlushE=1: load 0 (priority over StallE).
  - Else StallE=1: hold.
  - Else load the D bundle.
- E-stage combinational:
  - CondExE = cond_check(CondE, Flags).
  - RegWriteEc = RegWriteE & CondExE & ~NoWriteE.
  - MemWriteEc = MemWriteE & CondExE.
  - PCSrcEc = PCSrcE & CondExE.
  - BranchTakenE = BranchE & CondExE.
- Flag update (registered):
  - Enabled only when ~StallE & ~FlushE & CondExE.
  - FlagWriteE[1] -> Flags[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0] -> Flags[1:0] <= ALUFlags[1:0].
  - A stalled E instruction writes flags exactly once: on the cycle it advances.
- E->M register:
  - FlushM=1: load 0.
  - Else StallM=1: hold.
  - Else StallE=1: load bubble (all 0).
  - Else load {PCSrcEc, RegWriteEc, MemtoRegE, MemWriteEc, SideE}.
- M->W register:
  - StallM=1: load bubble.
  - Else load {PCSrcM, RegWriteM, MemtoRegM, SideM}.
  - W never stalls.
- Latency: D to W is 3 cycles with no stalls.
- Legal stall combinations: StallM=1 requires StallE=1. The bench asserts this; the RTL behaviour for StallM & ~StallE is undefined.
- Simultaneous FlushE & StallE: the flush wins, and the E contents are lost (hazard unit responsibility).
- Reset mid-stall: all state clears and the stall is forgotten.
- Condition codes (ARM):
  - EQ Z, NE ~Z
  - CS C, CC ~C
  - MI N, PL ~N
  - VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1
  - NV per NV_NEVER

Decomposition:
- Shared package ctrl_pkg:
  - Cond-code localparams (COND_EQ..COND_NV).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - FlagWrite bit indices.
- Sub-module cond_check: purely combinational (cond[3:0], flags[3:0]) -> pass, with parameter NV_NEVER. It is reused by the existing cond path.
- Pipeline registers are inline, with async reset, enable and synchronous clear.

Test Plan:
- ADDS then BEQ:
  - Stimulus: D1 FlagWriteD=2'b11, CondD=AL, ALUFlags=4'b0100; D2 CondD=EQ, BranchD=1.
  - Response: Flags=4'b0100 one cycle after D1 leaves E; BranchTakenE=1 while D2 is in E.
- Stall E for 3 cycles with FlagWriteE=2'b10 and ALUFlags toggling each cycle:
  - Flags update once, on the advance cycle, with the ALUFlags of that cycle.
  - M receives 3 bubbles (RegWriteM=0).
  - C,V are unchanged.
- Failed conditional store:
  - Stimulus: Flags Z=0, CondD=EQ, MemWriteD=1, RegWriteD=1.
  - Response: CondExE=0; MemWriteM=0 and RegWriteM=0 the next cycle; SideW still propagates.
- NoWrite compare:
  - Stimulus: RegWriteD=1, NoWriteD=1, FlagWriteD=2'b11.
  - Response: RegWriteM=0; Flags updated.
- Stall/flush priority:
  - Stimulus: FlushE=1 with StallE=1 and an E entry holding RegWriteE=1.
  - Response: E clears next cycle and the entry never reaches W.
  - Stimulus: FlushM pulse.
  - Response: RegWriteW=0 two cycles later.
- Reset mid-pipeline:
  - Stimulus: assert reset asynchronously between edges with all stages valid.
  - Response: all outputs 0 immediately; Flags=0; first post-reset instruction reaches W after 3 cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared condition-code, flag and flag-write definitions
package ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWrite[1] updates N,Z; FlagWrite[0] updates C,V
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/ctrl_pipe_stall_if.sv
// rtl/ctrl_pipe_stall_if.sv - D/E/M/W control pipeline signal bundle
interface ctrl_pipe_stall_if #(
  parameter int ALU_W  = 3,
  parameter int SIDE_W = 8
);
  logic [3:0]        CondD;
  logic              PCSrcD, RegWriteD, MemtoRegD, MemWriteD;
  logic              BranchD, ALUSrcD, NoWriteD, IgRnD;
  logic [ALU_W-1:0]  ALUControlD;
  logic [1:0]        FlagWriteD;
  logic [SIDE_W-1:0] SideD;
  logic [3:0]        ALUFlags;
  logic              StallE, StallM, FlushE, FlushM;

  logic [ALU_W-1:0]  ALUControlE;
  logic              ALUSrcE, MemtoRegE, IgRnE, PCSrcE;
  logic              CondExE, BranchTakenE;
  logic [3:0]        Flags;
  logic              PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [SIDE_W-1:0] SideM;
  logic              PCSrcW, RegWriteW, MemtoRegW;
  logic [SIDE_W-1:0] SideW;

  modport master (
    output CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
           NoWriteD, IgRnD, ALUControlD, FlagWriteD, SideD, ALUFlags,
           StallE, StallM, FlushE, FlushM,
    input  ALUControlE, ALUSrcE, MemtoRegE, IgRnE, PCSrcE, CondExE, BranchTakenE,
           Flags, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, SideM,
           PCSrcW, RegWriteW, MemtoRegW, SideW
  );

  modport slave (
    input  CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
           NoWriteD, IgRnD, ALUControlD, FlagWriteD, SideD, ALUFlags,
           StallE, StallM, FlushE, FlushM,
    output ALUControlE, ALUSrcE, MemtoRegE, IgRnE, PCSrcE, CondExE, BranchTakenE,
           Flags, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, SideM,
           PCSrcW, RegWriteW, MemtoRegW, SideW
  );
endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluator against NZCV
module cond_check
  import ctrl_pkg::*;
#(
  parameter int NV_NEVER = 1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = (NV_NEVER == 0);
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_pipe_stall.sv
// rtl/ctrl_pipe_stall.sv - D/E/M/W control pipeline with NZCV and per-stage stall/flush
module ctrl_pipe_stall
  import ctrl_pkg::*;
#(
  parameter int ALU_W    = 3,
  parameter int SIDE_W   = 8,
  parameter int NV_NEVER = 1
) (
  input logic         clk,
  input logic         reset,
  ctrl_pipe_stall_if.slave bus
);
  // E stage
  logic [3:0]        r_cond_e;
  logic              r_pcsrc_e, r_regwrite_e, r_memtoreg_e, r_memwrite_e;
  logic              r_branch_e, r_alusrc_e, r_nowrite_e, r_igrn_e;
  logic [ALU_W-1:0]  r_alu_control_e;
  logic [1:0]        r_flagwrite_e;
  logic [SIDE_W-1:0] r_side_e;
  logic [3:0]        r_flags;
  // M stage
  logic              r_pcsrc_m, r_regwrite_m, r_memwrite_m, r_memtoreg_m;
  logic [SIDE_W-1:0] r_side_m;
  // W stage
  logic              r_pcsrc_w, r_regwrite_w, r_memtoreg_w;
  logic [SIDE_W-1:0] r_side_w;

  logic w_cond_ex_e, w_regwrite_ec, w_memwrite_ec, w_pcsrc_ec, w_flag_en;

  cond_check #(.NV_NEVER(NV_NEVER)) u_cond_check (
    .cond  (r_cond_e),
    .flags (r_flags),
    .pass  (w_cond_ex_e)
  );

  assign w_regwrite_ec = r_regwrite_e & w_cond_ex_e & ~r_nowrite_e;
  assign w_memwrite_ec = r_memwrite_e & w_cond_ex_e;
  assign w_pcsrc_ec    = r_pcsrc_e & w_cond_ex_e;
  // Flags commit only on the cycle the E instruction actually moves on
  assign w_flag_en     = ~bus.StallE & ~bus.FlushE & w_cond_ex_e;

  // D->E register: flush beats stall, otherwise capture decode outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.FlushE) begin
      r_cond_e        <= '0;
      r_pcsrc_e       <= 1'b0;
      r_regwrite_e    <= 1'b0;
      r_memtoreg_e    <= 1'b0;
      r_memwrite_e    <= 1'b0;
      r_branch_e      <= 1'b0;
      r_alusrc_e      <= 1'b0;
      r_nowrite_e     <= 1'b0;
      r_igrn_e        <= 1'b0;
      r_alu_control_e <= '0;
      r_flagwrite_e   <= '0;
      r_side_e        <= '0;
    end else if (!bus.StallE) begin
      r_cond_e        <= bus.CondD;
      r_pcsrc_e       <= bus.PCSrcD;
      r_regwrite_e    <= bus.RegWriteD;
      r_memtoreg_e    <= bus.MemtoRegD;
      r_memwrite_e    <= bus.MemWriteD;
      r_branch_e      <= bus.BranchD;
      r_alusrc_e      <= bus.ALUSrcD;
      r_nowrite_e     <= bus.NoWriteD;
      r_igrn_e        <= bus.IgRnD;
      r_alu_control_e <= bus.ALUControlD;
      r_flagwrite_e   <= bus.FlagWriteD;
      r_side_e        <= bus.SideD;
    end
  end

  // NZCV register, N/Z and C/V halves written independently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_flag_en) begin
      if (r_flagwrite_e[FW_NZ]) r_flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (r_flagwrite_e[FW_CV]) r_flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // E->M register: flush, hold, bubble behind a stalled E, or advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.FlushM || (bus.StallE && !bus.StallM)) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_side_m     <= '0;
    end else if (!bus.StallM) begin
      r_pcsrc_m    <= w_pcsrc_ec;
      r_regwrite_m <= w_regwrite_ec;
      r_memwrite_m <= w_memwrite_ec;
      r_memtoreg_m <= r_memtoreg_e;
      r_side_m     <= r_side_e;
    end
  end

  // M->W register: W never stalls, so a held M sends a bubble onward
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.StallM) begin
      r_pcsrc_w    <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_side_w     <= '0;
    end else begin
      r_pcsrc_w    <= r_pcsrc_m;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
      r_side_w     <= r_side_m;
    end
  end

  assign bus.ALUControlE  = r_alu_control_e;
  assign bus.ALUSrcE      = r_alusrc_e;
  assign bus.MemtoRegE    = r_memtoreg_e;
  assign bus.IgRnE        = r_igrn_e;
  assign bus.PCSrcE       = r_pcsrc_e;
  assign bus.CondExE      = w_cond_ex_e;
  assign bus.BranchTakenE = r_branch_e & w_cond_ex_e;
  assign bus.Flags        = r_flags;
  assign bus.PCSrcM       = r_pcsrc_m;
  assign bus.RegWriteM    = r_regwrite_m;
  assign bus.MemWriteM    = r_memwrite_m;
  assign bus.MemtoRegM    = r_memtoreg_m;
  assign bus.SideM        = r_side_m;
  assign bus.PCSrcW       = r_pcsrc_w;
  assign bus.RegWriteW    = r_regwrite_w;
  assign bus.MemtoRegW    = r_memtoreg_w;
  assign bus.SideW        = r_side_w;
endmodule
